if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch (F) stage of the 5-stage MIPS pipeline, directly upstream of the F/D pipeline register.
//   Owns the PC register, the next-PC select (PC+4 / branch / j / jr) and a wait-state-tolerant imem handshake.
//   Produces instrF, pcF and pcPlus4F for the F/D register, plus stallReq for the hazard unit.
//   Fetch faults (misaligned or out-of-range PC) emit a NOP with excF instead of a memory request.
// PARAMETERS
//   PC_RESET  32'h0000_3000  PC loaded on reset
//   IM_BASE   32'h0000_3000  first byte address of instruction memory
//   IM_WORDS  4096           imem depth in words; legal PC range is [IM_BASE, IM_BASE+4*IM_WORDS)
// PORTS
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous, active-low (0 = reset)
//   en             in   1   pipeline advance enable from hazard unit (same en drives F/D)
//   pcSelD         in   2   00 PC+4, 01 branch, 10 j/jal, 11 jr (from D stage)
//   branchTargetD  in   32  branch target computed in D
//   jumpIndexD     in   26  instr_index field of j/jal in D
//   jrTargetD      in   32  rs value for jr in D
//   imem_req       out  1   fetch request
//   imem_addr      out  32  word-aligned fetch address
//   imem_rdata     in   32  instruction data, valid when imem_ready=1
//   imem_ready     in   1   data-return strobe (may assert in the same cycle as req)
//   instrF         out  32  fetched instruction; 32'h0 (NOP) when not valid or on a fault
//   pcF            out  32  PC of instrF
//   pcPlus4F       out  32  pcF + 4, modulo 2^32
//   validF         out  1   instrF/pcF are meaningful this cycle
//   excF           out  1   AdEL fetch fault on pcF
//   stallReq       out  1   equals !validF; hazard unit must hold D and bubble E
// BEHAVIOUR
//   Reset (async assert, sync release): pc=PC_RESET, state=REQ, buffer=0. Outputs: imem_req=0, instrF=0, validF=0,
//     excF=0, stallReq=1 while reset is low. imem_req rises on the first cycle after release.
//   States:
//     REQ  : imem_req=1, imem_addr=pc, held stable until imem_ready.
//            ready & en  -> instrF=imem_rdata, validF=1 combinationally; pc<=nextPC; stay in REQ
//                           (zero-wait throughput: 1 instr/cycle).
//            ready & !en -> buffer<=imem_rdata; go to HOLD.
//            !ready      -> validF=0, instrF=0, stallReq=1; en is ignored and pc holds.
//     HOLD : imem_req=0; instrF=buffer, validF=1. en -> pc<=nextPC, go to REQ. !en -> stay.
//     FAULT: entered when pc is misaligned (pc[1:0]!=0) or outside the legal range. No request is issued.
//            instrF=0, validF=1, excF=1. en -> pc<=nextPC, go to REQ or FAULT by the new pc.
//   The fault check is applied on every pc load, including reset.
//   nextPC is evaluated only in the advancing cycle:
//     00: pcF+4 | 01: branchTargetD | 10: {pcF[31:28], jumpIndexD, 2'b00} | 11: jrTargetD.
//   Delay slot: the branch is in D while its slot is in F, so the redirect applies to the fetch after the slot.
//   D inputs are stable while stalled because the hazard unit holds D whenever stallReq=1.
//   pc never changes unless validF=1 and en=1. pcPlus4F wraps 32'hFFFF_FFFC -> 0.
//   A reset pulse mid-WAIT or mid-HOLD drops imem_req immediately.
//     A stale imem_ready arriving after release is ignored unless imem_req=1.
//   imem_rdata is not sampled unless imem_req=1 and imem_ready=1.
// TESTING
//   1 Release reset; imem_ready=1 every cycle; en=1; pcSelD=00 -> pcF 0x3000, 0x3004, 0x3008 on consecutive cycles,
//     validF=1 throughout.
//   2 imem_ready low 2 cycles at 0x3004 -> imem_req=1 and imem_addr=0x3004 for 3 cycles; instrF=0 and stallReq=1
//     for 2 cycles; then valid.
//   3 Data returns with en=0 -> HOLD: imem_req=0, instrF holds the returned word 3 cycles; en=1 -> next fetch 0x3008.
//   4 With pcF=0x3008: pcSelD=01, target 0x3100 -> next pcF=0x3100. pcSelD=10, index 0x0000C50 -> 0x0000_3140.
//   5 pcSelD=11, jrTargetD=0x3002 -> no imem_req, instrF=0, excF=1. jrTargetD=0x7000 (out of range) -> excF=1.
//   6 Drive reset=0 during a WAIT at 0x3010 -> imem_req=0 in the same cycle; after release first pcF=0x3000;
//     a late ready is ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select and a wait-state-tolerant imem handshake.
// Misaligned or out-of-range PCs produce a NOP flagged with excF instead of a memory request.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  pcSelD,
    input  logic [31:0] branchTargetD,
    input  logic [25:0] jumpIndexD,
    input  logic [31:0] jrTargetD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        validF,
    output logic        excF,
    output logic        stallReq
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_FAULT
    } state_t;

    // 33-bit bound so a memory ending at 2^32 does not wrap to zero
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IM_BASE) || ({1'b0, a} >= IM_END);
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] w_next_pc;
    logic        w_advance;
    logic        w_capture;
    logic        w_req;
    logic        w_valid;
    logic        w_exc;
    logic [31:0] w_instr;

    always_comb begin
        case (pcSelD)
            2'b00:   w_next_pc = r_pc + 32'd4;
            2'b01:   w_next_pc = branchTargetD;
            2'b10:   w_next_pc = {r_pc[31:28], jumpIndexD, 2'b00};
            default: w_next_pc = jrTargetD;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        w_exc        = 1'b0;
        w_instr      = '0;
        w_capture    = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = 1'b1;
                if (imem_ready) begin
                    w_valid = 1'b1;
                    w_instr = imem_rdata;
                    if (!en) begin
                        w_capture    = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                w_valid = 1'b1;
                w_instr = r_buf;
            end
            default: begin
                w_valid = 1'b1;
                w_exc   = 1'b1;
            end
        endcase
        w_advance = w_valid && en;
        if (w_advance) begin
            w_state_next = is_fault(w_next_pc) ? S_FAULT : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= is_fault(PC_RESET) ? S_FAULT : S_REQ;
            r_pc    <= PC_RESET;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_pc <= w_next_pc;
            end
            if (w_capture) begin
                r_buf <= imem_rdata;
            end
        end
    end

    // Outputs are gated by reset so a mid-cycle reset drops the request at once
    assign imem_req  = w_req && reset;
    assign imem_addr = r_pc;
    assign validF    = w_valid && reset;
    assign excF      = w_exc && reset;
    assign instrF    = reset ? w_instr : '0;
    assign stallReq  = !validF;
    assign pcF       = r_pc;
    assign pcPlus4F  = r_pc + 32'd4;

endmodule
